therm_gray_capture_7bit: RTL and testbench
==========================================

// Module: therm_gray_capture_7bit
// PURPOSE
//  Downstream stage of the 7-bit thermometer/Gray encoder. Samples its 7-bit thermometer word
//  and debounces it over STABLE_CYCLES clocks. Decodes it to 3-bit binary and Gray, and flags
//  bubble (non-monotonic) codes and multi-bit Gray steps. Presents each result through a
//  registered valid/ready output slot to the next consumer (display or logging).
// PARAMETERS
//  STABLE_CYCLES  2  consecutive identical accepted samples required before capture (>=1)
//  ERR_CNT_W      8  width of the saturating error counter
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          synchronous reset, active-low
//  therm       in   7          thermometer word from encoder
//  enable      in   1          encoder enable; 0 = input ignored
//  in_valid    in   1          therm qualifies this cycle
//  out_ready   in   1          consumer accepts slot contents
//  out_valid   out  1          slot holds an undelivered result
//  bin         out  3          binary value = popcount(therm)
//  gray        out  3          bin ^ (bin >> 1)
//  bubble_err  out  1          captured word was not a legal thermometer code
//  step_err    out  1          captured Gray differs from previous captured Gray in >1 bit
//  err_count   out  ERR_CNT_W  saturating count of captures with bubble_err or step_err
// BEHAVIOUR
//  Reset (rst_n=0 at edge): every output, last_therm, stab_cnt, armed, prev_gray, have_prev -> 0.
//  Reset overrides all other activity and discards any in-flight or held result.
//  Sample accepted when in_valid & enable. If enable=0 at an edge, stab_cnt -> 0 and armed -> 0.
//  Held slot contents are kept while enable=0.
//  Debounce on accepted edge:
//   - therm==last_therm and stab_cnt!=0: stab_cnt = min(stab_cnt+1, STABLE_CYCLES).
//   - Otherwise: last_therm=therm, stab_cnt=1, armed=1.
//   - in_valid=0 with enable=1: debounce state holds.
//  Capture: at the first edge where armed & stab_cnt==STABLE_CYCLES (post-update) & slot_free.
//   - slot_free = !out_valid | out_ready.
//   - Effects: armed -> 0; slot loads bin, gray, bubble_err, step_err; out_valid -> 1.
//   - If the slot is not free, capture is deferred; armed stays 1 until the slot frees.
//   - A value already captured is not captured again until therm changes.
//  Latency: therm stable from edge k with free slot -> out_valid high after edge k+STABLE_CYCLES-1.
//  Decode:
//   - legal iff (therm & (therm+1)) == 0, i.e. form 0..01..1.
//   - bin = popcount regardless of legality; bubble_err = !legal.
//  Step check: step_err = have_prev & (popcount(gray ^ prev_gray) > 1).
//   - On capture: prev_gray = gray, have_prev = 1.
//   - The first capture after reset never flags step_err.
//  err_count += 1 on a capture with bubble_err|step_err; it saturates at all-ones, no wrap.
//  Handshake:
//   - Slot contents and flags are stable while out_valid & !out_ready.
//   - out_valid & out_ready with no capture: out_valid -> 0; data regs keep last value.
//   - out_valid & out_ready with a capture at the same edge: new data loads, out_valid stays 1.
//  FSM (slot): EMPTY -(capture)-> FULL; FULL -(ready & !capture)-> EMPTY;
//   FULL -(ready & capture)-> FULL. Debounce is counter-based and is not part of the FSM.
// STRUCTURE
//  Package therm_pkg:
//   - THERM_W=7, BIN_W=3.
//   - Functions popcount7, bin2gray3, is_legal_therm, hamming3.
//  Sub-module therm_decode_comb (combinational): therm -> bin, gray, legal.
//  The top keeps only the debounce counter, slot FSM, prev_gray and err_count.
// TESTING
//  1 rst_n=0 for 2 edges amid random inputs -> all outputs 0; first capture after release
//    has step_err=0.
//  2 therm=0000111, enable=1, in_valid=1 for 2 edges, out_ready=1 -> out_valid after 2nd edge;
//    bin=3, gray=010, bubble_err=0.
//  3 Stable therm=0010111 -> bin=4, gray=110, bubble_err=1, err_count=1.
//  4 Captures 0000001 then 0000011 -> gray 001->011, step_err=0.
//    Then 0001111 -> gray 011->110, step_err=1, err_count +1.
//  5 Backpressure: out_ready=0 holding bin=3; then stable 0011111 ->
//    - bin stays 3 and out_valid stays 1;
//    - raise out_ready -> next edge bin=5, gray=111, out_valid=1.
//  6 Glitch/abort:
//    - therm alternating 0000011/0000111 each edge -> no capture.
//    - enable=0 after 1 stable edge -> no capture until 2 new stable edges.
//    - err_count forced to 255 + 1 error -> stays 255.

Source files
------------

// File: rtl/therm_gray_capture_7bit_pkg.sv
// -----------------------------------------------------------------------------
// therm_pkg
// Shared widths, slot state type and small decode helpers for the
// thermometer-to-Gray capture stage.
//   THERM_W        : width of the incoming thermometer word
//   BIN_W          : width of the decoded binary / Gray value
//   slot_state_t   : output slot FSM states
//   popcount7      : number of ones in a thermometer word
//   bin2gray3      : binary to reflected Gray
//   is_legal_therm : true for words of the form 0..01..1
//   hamming3       : number of differing bits between two 3-bit values
// -----------------------------------------------------------------------------
package therm_pkg;

    localparam int THERM_W = 7;
    localparam int BIN_W   = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Counts ones without regard to ordering, so bubble codes still yield a value.
    function automatic logic [BIN_W-1:0] popcount7(input logic [THERM_W-1:0] t);
        logic [BIN_W-1:0] count;
        count = '0;
        for (int i = 0; i < THERM_W; i++) begin
            count = count + BIN_W'(t[i]);
        end
        return count;
    endfunction

    function automatic logic [BIN_W-1:0] bin2gray3(input logic [BIN_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Adding one to a word of trailing ones carries out cleanly, leaving no
    // overlap with the original; any hole below a set bit leaves an overlap.
    function automatic logic is_legal_therm(input logic [THERM_W-1:0] t);
        return (t & (t + THERM_W'(1))) == '0;
    endfunction

    function automatic logic [1:0] hamming3(input logic [BIN_W-1:0] a,
                                            input logic [BIN_W-1:0] b);
        logic [BIN_W-1:0] diff;
        diff = a ^ b;
        return {1'b0, diff[0]} + {1'b0, diff[1]} + {1'b0, diff[2]};
    endfunction

endpackage

// File: rtl/therm_gray_capture_7bit_if.sv
// -----------------------------------------------------------------------------
// therm_gray_capture_7bit_if
// Bundles the encoder-facing input qualifiers and the consumer-facing result
// slot of the capture stage.
//   therm, enable, in_valid : word from the encoder and its qualifiers
//   out_ready               : consumer accepts the slot contents
//   out_valid               : slot holds an undelivered result
//   bin, gray               : decoded value of the captured word
//   bubble_err, step_err    : error flags of the captured word
//   err_count               : saturating count of flagged captures
// Modports: master drives the inputs and observes the slot, slave is the stage.
// -----------------------------------------------------------------------------
interface therm_gray_capture_7bit_if #(
    parameter int ERR_CNT_W = 8
) ();

    logic [therm_pkg::THERM_W-1:0] therm;
    logic                          enable;
    logic                          in_valid;
    logic                          out_ready;
    logic                          out_valid;
    logic [therm_pkg::BIN_W-1:0]   bin;
    logic [therm_pkg::BIN_W-1:0]   gray;
    logic                          bubble_err;
    logic                          step_err;
    logic [ERR_CNT_W-1:0]          err_count;

    modport master (
        output therm, enable, in_valid, out_ready,
        input  out_valid, bin, gray, bubble_err, step_err, err_count
    );

    modport slave (
        input  therm, enable, in_valid, out_ready,
        output out_valid, bin, gray, bubble_err, step_err, err_count
    );

endinterface

// File: rtl/therm_gray_capture_7bit_decode.sv
// -----------------------------------------------------------------------------
// therm_decode_comb
// Purely combinational decode of one thermometer word.
//   i_therm : thermometer word
//   o_bin   : popcount of the word, valid even for bubble codes
//   o_gray  : Gray form of o_bin
//   o_legal : word has the form 0..01..1
// -----------------------------------------------------------------------------
module therm_decode_comb
    import therm_pkg::*;
(
    input  logic [THERM_W-1:0] i_therm,
    output logic [BIN_W-1:0]   o_bin,
    output logic [BIN_W-1:0]   o_gray,
    output logic               o_legal
);

    logic [BIN_W-1:0] w_bin;

    // Gray is derived from the popcount so both outputs always agree.
    always_comb begin
        w_bin   = popcount7(i_therm);
        o_bin   = w_bin;
        o_gray  = bin2gray3(w_bin);
        o_legal = is_legal_therm(i_therm);
    end

endmodule

// File: rtl/therm_gray_capture_7bit.sv
// -----------------------------------------------------------------------------
// therm_gray_capture_7bit
// Debounces the encoder's thermometer word, decodes it and hands each stable
// value to the next consumer through a single registered valid/ready slot.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active-low
//   bus   : slave side of therm_gray_capture_7bit_if (inputs, result slot)
// Parameters:
//   STABLE_CYCLES : identical accepted samples needed before a capture (>=1)
//   ERR_CNT_W     : width of the saturating error counter
// -----------------------------------------------------------------------------
module therm_gray_capture_7bit
    import therm_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    therm_gray_capture_7bit_if.slave      bus
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  STAB_MAX = CNT_W'(STABLE_CYCLES);

    logic [THERM_W-1:0]   r_lastTherm;
    logic [CNT_W-1:0]     r_stabCnt;
    logic                 r_armed;
    logic [BIN_W-1:0]     r_prevGray;
    logic                 r_havePrev;
    slot_state_t          r_state;
    logic                 r_outValid;
    logic [BIN_W-1:0]     r_bin;
    logic [BIN_W-1:0]     r_gray;
    logic                 r_bubbleErr;
    logic                 r_stepErr;
    logic [ERR_CNT_W-1:0] r_errCount;

    logic [BIN_W-1:0]     w_bin;
    logic [BIN_W-1:0]     w_gray;
    logic                 w_legal;
    logic [THERM_W-1:0]   w_lastNext;
    logic [CNT_W-1:0]     w_stabNext;
    logic                 w_armedNext;
    logic                 w_slotFree;
    logic                 w_capture;
    logic                 w_stepErr;
    logic                 w_anyErr;

    therm_decode_comb u_decode (
        .i_therm (bus.therm),
        .o_bin   (w_bin),
        .o_gray  (w_gray),
        .o_legal (w_legal)
    );

    // Next debounce state. The capture decision looks at the post-update count,
    // so a word first seen at edge k is captured at edge k+STABLE_CYCLES-1.
    // Armed marks a value that has not been captured yet; it only re-arms when
    // the word changes or the count restarts after enable dropped.
    always_comb begin
        w_lastNext  = r_lastTherm;
        w_stabNext  = r_stabCnt;
        w_armedNext = r_armed;
        if (!bus.enable) begin
            w_stabNext  = '0;
            w_armedNext = 1'b0;
        end else if (bus.in_valid) begin
            if (bus.therm == r_lastTherm && r_stabCnt != '0) begin
                if (r_stabCnt != STAB_MAX) begin
                    w_stabNext = r_stabCnt + CNT_W'(1);
                end
            end else begin
                w_lastNext  = bus.therm;
                w_stabNext  = CNT_W'(1);
                w_armedNext = 1'b1;
            end
        end
        w_slotFree = !r_outValid || bus.out_ready;
        w_capture  = w_armedNext && (w_stabNext == STAB_MAX) && w_slotFree;
        w_stepErr  = r_havePrev && (hamming3(w_gray, r_prevGray) > 2'd1);
        w_anyErr   = !w_legal || w_stepErr;
    end

    // All state lives here: debounce registers, the slot FSM with its registered
    // outputs, the previous-Gray reference and the saturating error counter.
    // A capture while the consumer is taking the old result keeps the slot full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lastTherm <= '0;
            r_stabCnt   <= '0;
            r_armed     <= 1'b0;
            r_prevGray  <= '0;
            r_havePrev  <= 1'b0;
            r_state     <= SLOT_EMPTY;
            r_outValid  <= 1'b0;
            r_bin       <= '0;
            r_gray      <= '0;
            r_bubbleErr <= 1'b0;
            r_stepErr   <= 1'b0;
            r_errCount  <= '0;
        end else begin
            r_lastTherm <= w_lastNext;
            r_stabCnt   <= w_stabNext;
            r_armed     <= w_armedNext && !w_capture;

            case (r_state)
                SLOT_EMPTY: begin
                    if (w_capture) begin
                        r_state    <= SLOT_FULL;
                        r_outValid <= 1'b1;
                    end
                end
                SLOT_FULL: begin
                    if (!w_capture && bus.out_ready) begin
                        r_state    <= SLOT_EMPTY;
                        r_outValid <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= SLOT_EMPTY;
                    r_outValid <= 1'b0;
                end
            endcase

            if (w_capture) begin
                r_bin       <= w_bin;
                r_gray      <= w_gray;
                r_bubbleErr <= !w_legal;
                r_stepErr   <= w_stepErr;
                r_prevGray  <= w_gray;
                r_havePrev  <= 1'b1;
                if (w_anyErr && r_errCount != '1) begin
                    r_errCount <= r_errCount + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign bus.out_valid  = r_outValid;
    assign bus.bin        = r_bin;
    assign bus.gray       = r_gray;
    assign bus.bubble_err = r_bubbleErr;
    assign bus.step_err   = r_stepErr;
    assign bus.err_count  = r_errCount;

endmodule

// File: tb/tb_therm_gray_capture_7bit.sv
// -----------------------------------------------------------------------------
// tb_therm_gray_capture_7bit
// Directed vector table for therm_gray_capture_7bit followed by hand-written
// sequences for latency, error-counter saturation and enable-low hold.
// -----------------------------------------------------------------------------
module tb_therm_gray_capture_7bit;

    typedef struct {
        logic       rstN;
        logic [6:0] therm;
        logic       en;
        logic       iv;
        logic       rdy;
        logic       expValid;
        logic [2:0] expBin;
        logic [2:0] expGray;
        logic       expBub;
        logic       expStep;
        logic [7:0] expCnt;
    } vec_t;

    localparam int NVEC = 35;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    therm_gray_capture_7bit_if #(.ERR_CNT_W(8)) bus ();

    therm_gray_capture_7bit #(
        .STABLE_CYCLES (2),
        .ERR_CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rstN),
        .bus   (bus.slave)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [6:0] t, input logic e,
                                input logic v, input logic rd, input logic ev,
                                input logic [2:0] eb, input logic [2:0] eg,
                                input logic ebub, input logic estep, input logic [7:0] ec);
        vec_t x;
        x.rstN = r;   x.therm = t;   x.en = e;     x.iv = v;       x.rdy = rd;
        x.expValid = ev; x.expBin = eb; x.expGray = eg; x.expBub = ebub;
        x.expStep = estep; x.expCnt = ec;
        return x;
    endfunction

    // Drive one set of inputs, let one rising edge pass, then settle just after it.
    task automatic applyStimulus(input logic r, input logic [6:0] t, input logic e,
                                 input logic v, input logic rd);
        rstN          = r;
        bus.therm     = t;
        bus.enable    = e;
        bus.in_valid  = v;
        bus.out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s step %0d got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t x);
        checkField("out_valid",  idx, 32'(bus.out_valid),  32'(x.expValid));
        checkField("bin",        idx, 32'(bus.bin),        32'(x.expBin));
        checkField("gray",       idx, 32'(bus.gray),       32'(x.expGray));
        checkField("bubble_err", idx, 32'(bus.bubble_err), 32'(x.expBub));
        checkField("step_err",   idx, 32'(bus.step_err),   32'(x.expStep));
        checkField("err_count",  idx, 32'(bus.err_count),  32'(x.expCnt));
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;

        // Reset amid arbitrary inputs, then plain captures of legal and bubble words.
        vecs[0]  = mk(0, 7'b1010101, 1, 1, 0,  0, 3'd0, 3'b000, 0, 0, 8'd0);
        vecs[1]  = mk(0, 7'b1111111, 0, 1, 1,  0, 3'd0, 3'b000, 0, 0, 8'd0);
        vecs[2]  = mk(1, 7'b0000111, 1, 1, 1,  0, 3'd0, 3'b000, 0, 0, 8'd0);
        vecs[3]  = mk(1, 7'b0000111, 1, 1, 1,  1, 3'd3, 3'b010, 0, 0, 8'd0);
        vecs[4]  = mk(1, 7'b0000111, 1, 1, 1,  0, 3'd3, 3'b010, 0, 0, 8'd0);
        vecs[5]  = mk(1, 7'b0010111, 1, 1, 1,  0, 3'd3, 3'b010, 0, 0, 8'd0);
        vecs[6]  = mk(1, 7'b0010111, 1, 1, 1,  1, 3'd4, 3'b110, 1, 0, 8'd1);
        // Gray steps: 110->001 (3 bits), 001->011 (1 bit), 011->110 (2 bits).
        vecs[7]  = mk(1, 7'b0000001, 1, 1, 1,  0, 3'd4, 3'b110, 1, 0, 8'd1);
        vecs[8]  = mk(1, 7'b0000001, 1, 1, 1,  1, 3'd1, 3'b001, 0, 1, 8'd2);
        vecs[9]  = mk(1, 7'b0000011, 1, 1, 1,  0, 3'd1, 3'b001, 0, 1, 8'd2);
        vecs[10] = mk(1, 7'b0000011, 1, 1, 1,  1, 3'd2, 3'b011, 0, 0, 8'd2);
        vecs[11] = mk(1, 7'b0001111, 1, 1, 1,  0, 3'd2, 3'b011, 0, 0, 8'd2);
        vecs[12] = mk(1, 7'b0001111, 1, 1, 1,  1, 3'd4, 3'b110, 0, 1, 8'd3);
        // Backpressure: bin=3 held while a stable 0011111 waits for the slot.
        vecs[13] = mk(1, 7'b0000111, 1, 1, 1,  0, 3'd4, 3'b110, 0, 1, 8'd3);
        vecs[14] = mk(1, 7'b0000111, 1, 1, 0,  1, 3'd3, 3'b010, 0, 0, 8'd3);
        vecs[15] = mk(1, 7'b0011111, 1, 1, 0,  1, 3'd3, 3'b010, 0, 0, 8'd3);
        vecs[16] = mk(1, 7'b0011111, 1, 1, 0,  1, 3'd3, 3'b010, 0, 0, 8'd3);
        vecs[17] = mk(1, 7'b0011111, 1, 1, 0,  1, 3'd3, 3'b010, 0, 0, 8'd3);
        vecs[18] = mk(1, 7'b0011111, 1, 1, 1,  1, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[19] = mk(1, 7'b0011111, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        // Alternating words never settle, so nothing is captured.
        vecs[20] = mk(1, 7'b0000011, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[21] = mk(1, 7'b0000111, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[22] = mk(1, 7'b0000011, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[23] = mk(1, 7'b0000111, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        // Enable drop after one stable edge restarts the count.
        vecs[24] = mk(1, 7'b0111111, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[25] = mk(1, 7'b0111111, 0, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[26] = mk(1, 7'b0111111, 1, 1, 1,  0, 3'd5, 3'b111, 0, 1, 8'd4);
        vecs[27] = mk(1, 7'b0111111, 1, 1, 1,  1, 3'd6, 3'b101, 0, 0, 8'd4);
        // in_valid low freezes the debounce count.
        vecs[28] = mk(1, 7'b0111111, 1, 0, 1,  0, 3'd6, 3'b101, 0, 0, 8'd4);
        vecs[29] = mk(1, 7'b0000001, 1, 1, 1,  0, 3'd6, 3'b101, 0, 0, 8'd4);
        vecs[30] = mk(1, 7'b0000001, 1, 0, 1,  0, 3'd6, 3'b101, 0, 0, 8'd4);
        vecs[31] = mk(1, 7'b0000001, 1, 1, 1,  1, 3'd1, 3'b001, 0, 0, 8'd4);
        // Reset discards a held result; the first capture after it has no step check.
        vecs[32] = mk(0, 7'b0110110, 1, 1, 0,  0, 3'd0, 3'b000, 0, 0, 8'd0);
        vecs[33] = mk(1, 7'b0000011, 1, 1, 1,  0, 3'd0, 3'b000, 0, 0, 8'd0);
        vecs[34] = mk(1, 7'b0000011, 1, 1, 1,  1, 3'd2, 3'b011, 0, 0, 8'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].therm, vecs[i].en, vecs[i].iv, vecs[i].rdy);
            checkOutput(i, vecs[i]);
        end

        // Latency: a new stable word becomes visible two edges after it appears.
        n = 0;
        rstN = 1'b1; bus.therm = 7'b0000111; bus.enable = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(bus.out_valid === 1'b1 && bus.bin === 3'd3) && n < 10);
        checkField("latency_edges", 100, 32'(n), 32'd2);
        checkField("latency_gray", 100, 32'(bus.gray), 32'b010);

        // Saturation: 260 bubble captures alternating two illegal popcount-4 words.
        for (int i = 0; i < 260; i++) begin
            logic [6:0] w;
            w = (i % 2 == 0) ? 7'b0010111 : 7'b0101011;
            applyStimulus(1'b1, w, 1'b1, 1'b1, 1'b1);
            applyStimulus(1'b1, w, 1'b1, 1'b1, 1'b1);
            if (i == 253) checkField("err_count_254", 200, 32'(bus.err_count), 32'd254);
            if (i == 254) checkField("err_count_255", 201, 32'(bus.err_count), 32'd255);
        end
        checkField("err_count_sat", 202, 32'(bus.err_count), 32'd255);
        checkField("sat_valid", 203, 32'(bus.out_valid), 32'd1);
        checkField("sat_bubble", 204, 32'(bus.bubble_err), 32'd1);
        checkField("sat_bin", 205, 32'(bus.bin), 32'd4);

        // Enable low with a stable new word: slot holds, nothing new is captured.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 7'b0000001, 1'b0, 1'b1, 1'b0);
        end
        checkField("en0_valid", 300, 32'(bus.out_valid), 32'd1);
        checkField("en0_bin", 301, 32'(bus.bin), 32'd4);
        checkField("en0_count", 302, 32'(bus.err_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
